// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } q_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with registered storage, synchronous flush and occupancy count.
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    cnt_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty     = (cnt_r == {CW{1'b0}});
    assign full      = (cnt_r == CW'(DEPTH));
    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = cnt_r;

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            cnt_r <= cnt_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Entry storage; contents are meaningless outside the occupied window.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !rst) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/if_prefetch_queue_chk.sv
// Protocol and credit invariants of the prefetch front end.
module if_prefetch_queue_chk #(
    parameter int QDEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        accept,
    input  logic                        rsp_valid,
    input  logic                        q_push,
    input  logic                        q_pop,
    input  logic                        q_full,
    input  logic                        pcf_empty,
    input  logic [$clog2(QDEPTH+1)-1:0] pcf_count,
    input  logic [$clog2(QDEPTH+1)-1:0] outstanding,
    input  logic [$clog2(QDEPTH+1)-1:0] drop_cnt
);

    localparam int CW = $clog2(QDEPTH + 1);

    a_q_no_overflow:   assert property (@(posedge clk) disable iff (rst) (q_push && q_full) |-> q_pop);
    a_rsp_has_tag:     assert property (@(posedge clk) disable iff (rst) rsp_valid |-> !pcf_empty);
    a_out_no_overflow: assert property (@(posedge clk) disable iff (rst)
                                        (accept && !rsp_valid) |-> (outstanding < CW'(QDEPTH)));
    a_out_no_underflow: assert property (@(posedge clk) disable iff (rst)
                                         (rsp_valid && !accept) |-> (outstanding != {CW{1'b0}}));
    a_drop_le_out:     assert property (@(posedge clk) disable iff (rst) drop_cnt <= outstanding);
    a_tag_count:       assert property (@(posedge clk) disable iff (rst) pcf_count == outstanding);

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: credit-limited in-order requests, prefetch queue toward decode,
// and redirect handling that discards responses still in flight on the old path.
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   fetch_pc_nxt_s;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] outstanding_nxt_s;
    logic [CW-1:0] drop_cnt_r;
    logic [CW-1:0] drop_cnt_nxt_s;
    logic [CW:0]   inflight_s;
    logic          accept_s;
    logic          drop_now_s;
    logic          q_push_s;
    logic          q_pop_s;
    logic          q_empty_s;
    logic          q_full_s;
    logic [CW-1:0] q_count_s;
    q_entry_t      q_wdata_s;
    q_entry_t      q_head_s;
    logic [31:0]   pcf_head_s;
    logic          pcf_empty_s;
    logic          pcf_full_s;
    logic [CW-1:0] pcf_count_s;

    // Queued entries plus in-flight requests never exceed the queue depth, so every response has a slot.
    assign inflight_s     = {1'b0, q_count_s} + {1'b0, outstanding_r};
    assign imem_req_valid = ~rst & ~redirect_valid & (inflight_s < (CW+1)'(QDEPTH));
    assign imem_req_addr  = fetch_pc_r;
    assign accept_s       = imem_req_valid & imem_req_ready;

    assign drop_now_s = imem_rsp_valid & (drop_cnt_r != {CW{1'b0}});
    assign q_push_s   = imem_rsp_valid & ~drop_now_s & ~redirect_valid;
    assign q_pop_s    = id_valid & id_ready;
    assign q_wdata_s  = '{pc: pcf_head_s, instr: imem_rsp_data};

    assign id_valid    = ~q_empty_s;
    assign id_instr    = q_head_s.instr;
    assign id_pc       = q_head_s.pc;
    assign id_pc_plus4 = q_head_s.pc + PC_STEP;

    // In-flight count after this cycle's accept and response.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        case ({accept_s, imem_rsp_valid})
            2'b10:   outstanding_nxt_s = outstanding_r + CW'(1);
            2'b01:   outstanding_nxt_s = outstanding_r - CW'(1);
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Next fetch PC and drop count; a redirect marks every remaining in-flight response as stale.
    always_comb begin
        fetch_pc_nxt_s = fetch_pc_r;
        drop_cnt_nxt_s = drop_cnt_r;
        if (redirect_valid) begin
            fetch_pc_nxt_s = word_align(redirect_pc);
            drop_cnt_nxt_s = outstanding_nxt_s;
        end else begin
            if (accept_s) begin
                fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (drop_now_s) begin
                drop_cnt_nxt_s = drop_cnt_r - CW'(1);
            end else begin
                drop_cnt_nxt_s = drop_cnt_r;
            end
        end
    end

    // Fetch PC and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
        end else begin
            fetch_pc_r    <= fetch_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
        end
    end

    if_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(q_entry_t))
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (q_push_s),
        .wdata (q_wdata_s),
        .pop   (q_pop_s),
        .rdata (q_head_s),
        .empty (q_empty_s),
        .full  (q_full_s),
        .count (q_count_s)
    );

    // Request-address tags; not flushed on redirect because stale responses still retire their tag.
    if_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (32)
    ) u_pc_tags (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (accept_s),
        .wdata (fetch_pc_r),
        .pop   (imem_rsp_valid),
        .rdata (pcf_head_s),
        .empty (pcf_empty_s),
        .full  (pcf_full_s),
        .count (pcf_count_s)
    );

    if_prefetch_queue_chk #(
        .QDEPTH (QDEPTH)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .accept      (accept_s & ~pcf_full_s | accept_s & imem_rsp_valid),
        .rsp_valid   (imem_rsp_valid),
        .q_push      (q_push_s),
        .q_pop       (q_pop_s),
        .q_full      (q_full_s),
        .pcf_empty   (pcf_empty_s),
        .pcf_count   (pcf_count_s),
        .outstanding (outstanding_r),
        .drop_cnt    (drop_cnt_r)
    );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench: two fronts ends (reset PC 0 and FFFF_FFF8) driven by a latency-configurable memory model.
module tb_if_prefetch_queue;

    localparam logic [31:0] KEY = 32'h5A5A_0F0F;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_ready = 1'b1;

    logic        req_valid0, req_valid1;
    logic [31:0] req_addr0, req_addr1;
    logic        rsp_valid0 = 1'b0, rsp_valid1 = 1'b0;
    logic [31:0] rsp_data0 = 32'd0, rsp_data1 = 32'd0;
    logic        id_valid0, id_valid1;
    logic [31:0] id_instr0, id_instr1, id_pc0, id_pc1, id_plus40, id_plus41;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    mreq_t       mq0[$];
    mreq_t       mq1[$];
    logic [31:0] dlv0[$];
    logic [31:0] dlv1[$];
    logic [31:0] acc0[$];
    int          acc_cyc0[$];

    always #5 clk = ~clk;

    if_prefetch_queue #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid0), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr0),
        .imem_rsp_valid(rsp_valid0), .imem_rsp_data(rsp_data0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid0), .id_ready(id_ready), .id_instr(id_instr0), .id_pc(id_pc0),
        .id_pc_plus4(id_plus40)
    );

    if_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid1), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr1),
        .imem_rsp_valid(rsp_valid1), .imem_rsp_data(rsp_data1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid1), .id_ready(id_ready), .id_instr(id_instr1), .id_pc(id_pc1),
        .id_pc_plus4(id_plus41)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // sel: 0 = dut0 delivered PCs, 1 = dut1 delivered PCs, 2 = dut0 accepted addresses
    task automatic chk_log(input string tag, input int sel, input int idx, input logic [31:0] exp);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        if (sel == 0 && idx < dlv0.size()) v = dlv0[idx];
        if (sel == 1 && idx < dlv1.size()) v = dlv1[idx];
        if (sel == 2 && idx < acc0.size()) v = acc0[idx];
        chk(tag, v, exp);
    endtask

    task automatic tick();
        logic        a0, a1, p0, p1, r0, r1;
        logic [31:0] ad0, ad1, pc0, pc1;
        #1;
        a0 = req_valid0 & imem_req_ready;  ad0 = req_addr0;
        a1 = req_valid1 & imem_req_ready;  ad1 = req_addr1;
        p0 = id_valid0 & id_ready;         pc0 = id_pc0;
        p1 = id_valid1 & id_ready;         pc1 = id_pc1;
        r0 = rsp_valid0;                   r1 = rsp_valid1;
        if (p0) begin
            dlv0.push_back(pc0);
            chk("instr0", id_instr0, pc0 ^ KEY);
            chk("plus4_0", id_plus40, pc0 + 32'd4);
        end
        if (p1) begin
            dlv1.push_back(pc1);
            chk("instr1", id_instr1, pc1 ^ KEY);
            chk("plus4_1", id_plus41, pc1 + 32'd4);
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq0.delete();
            mq1.delete();
        end else begin
            if (r0 && mq0.size() > 0) void'(mq0.pop_front());
            if (r1 && mq1.size() > 0) void'(mq1.pop_front());
            if (a0) begin
                mq0.push_back('{addr: ad0, due: cyc - 1 + lat});
                acc0.push_back(ad0);
                acc_cyc0.push_back(cyc - 1);
            end
            if (a1) mq1.push_back('{addr: ad1, due: cyc - 1 + lat});
        end
        #1;
        rsp_valid0 = (mq0.size() > 0) && (mq0[0].due <= cyc);
        rsp_data0  = rsp_valid0 ? (mq0[0].addr ^ KEY) : 32'd0;
        rsp_valid1 = (mq1.size() > 0) && (mq1[0].due <= cyc);
        rsp_data1  = rsp_valid1 ? (mq1[0].addr ^ KEY) : 32'd0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench in the first cycle after reset release with empty logs.
    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        dlv0.delete(); dlv1.delete(); acc0.delete(); acc_cyc0.delete();
    endtask

    initial begin
        int olds;

        // 1 / 5: reset release, streaming, reset-PC wrap on dut1
        lat = 1; id_ready = 1'b1;
        rst = 1'b1;
        ticks(2);
        #1;
        chk("rst_req_valid", 32'(req_valid0), 32'd0);
        chk("rst_id_valid", 32'(id_valid0), 32'd0);
        rst = 1'b0;
        dlv0.delete(); dlv1.delete(); acc0.delete(); acc_cyc0.delete();
        #1;
        chk("c1_id_valid", 32'(id_valid0), 32'd0);
        tick();
        chk("c2_id_valid", 32'(id_valid0), 32'd0);
        tick();
        chk("c3_id_valid", 32'(id_valid0), 32'd1);
        chk("c3_id_pc", id_pc0, 32'h0);
        chk("c3_plus4", id_plus40, 32'h4);
        chk("c3_id_pc_w", id_pc1, 32'hFFFF_FFF8);
        tick();
        chk("c4_id_pc", id_pc0, 32'h4);
        chk("c4_id_pc_w", id_pc1, 32'hFFFF_FFFC);
        chk("c4_plus4_wrap", id_plus41, 32'h0);
        ticks(4);
        chk_log("req_addr0", 2, 0, 32'h0);
        chk_log("req_addr1", 2, 1, 32'h4);
        chk_log("req_addr2", 2, 2, 32'h8);
        chk("req_back2back", 32'(acc_cyc0[2] - acc_cyc0[0]), 32'd2);
        chk_log("wrap_pc0", 1, 0, 32'hFFFF_FFF8);
        chk_log("wrap_pc1", 1, 1, 32'hFFFF_FFFC);
        chk_log("wrap_pc2", 1, 2, 32'h0000_0000);

        // 2: decode stalled fills exactly QDEPTH entries
        id_ready = 1'b0;
        do_reset();
        ticks(10);
        chk("stall_req_count", 32'(acc0.size()), 32'd4);
        chk("stall_req_valid", 32'(req_valid0), 32'd0);
        chk("stall_id_valid", 32'(id_valid0), 32'd1);
        chk("stall_id_pc", id_pc0, 32'h0);
        chk("stall_id_instr", id_instr0, 32'h0 ^ KEY);
        chk("stall_no_pop", 32'(dlv0.size()), 32'd0);
        id_ready = 1'b1;
        ticks(8);
        chk_log("drain_pc0", 0, 0, 32'h0);
        chk_log("drain_pc1", 0, 1, 32'h4);
        chk_log("drain_pc2", 0, 2, 32'h8);
        chk_log("drain_pc3", 0, 3, 32'hC);
        chk_log("resume_addr", 2, 4, 32'h10);

        // 3: L=3, redirect with 3 outstanding
        lat = 3; id_ready = 1'b1;
        do_reset();
        ticks(3);
        chk("l3_outstanding", 32'(acc0.size()), 32'd3);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("redir_no_req", 32'(req_valid0), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_id_valid", 32'(id_valid0), 32'd0);
        ticks(14);
        chk_log("redir_first", 0, 0, 32'h40);
        chk_log("redir_second", 0, 1, 32'h44);
        olds = 0;
        foreach (dlv0[i]) if (dlv0[i] < 32'h40) olds++;
        chk("redir_no_old", 32'(olds), 32'd0);

        // 4: misaligned redirect and back-to-back redirects
        lat = 1;
        do_reset();
        ticks(3);
        redirect_valid = 1'b1; redirect_pc = 32'h83;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("align_req_valid", 32'(req_valid0), 32'd1);
        chk("align_req_addr", req_addr0, 32'h80);
        ticks(3);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        dlv0.delete();
        ticks(10);
        chk_log("b2b_first", 0, 0, 32'h200);
        chk_log("b2b_second", 0, 1, 32'h204);
        olds = 0;
        foreach (dlv0[i]) if (dlv0[i] < 32'h200) olds++;
        chk("b2b_no_old", 32'(olds), 32'd0);

        // 6: reset mid-stream with queued entries and in-flight requests
        lat = 3; id_ready = 1'b0;
        do_reset();
        ticks(5);
        chk("mid_req_count", 32'(acc0.size()), 32'd4);
        chk("mid_id_valid", 32'(id_valid0), 32'd1);
        rst = 1'b1;
        tick();
        #1;
        chk("mid_rst_id_valid", 32'(id_valid0), 32'd0);
        chk("mid_rst_req_valid", 32'(req_valid0), 32'd0);
        rst = 1'b0;
        dlv0.delete(); acc0.delete(); acc_cyc0.delete();
        id_ready = 1'b1;
        ticks(12);
        chk_log("restart_addr", 2, 0, 32'h0);
        chk_log("restart_pc0", 0, 0, 32'h0);
        chk_log("restart_pc1", 0, 1, 32'h4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
